// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package prog_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int unsigned BYTES_PER_WORD = 2;

    // States in which the loader is inside a frame and waiting on the byte stream.
    function automatic logic is_frame_state(input state_t s);
        return (s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK});
    endfunction

endpackage

// File: rtl/prog_loader_byte_timeout.sv
// Inter-byte idle counter; pulses expired_o when TIMEOUT_CYCLES-1 idle clocks have elapsed.
module byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over counting so an accepted byte always restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/prog_loader.sv
// Frames a byte stream into 16-bit instruction words, writes them to the
// instruction RAM and releases the CPU only after a checksum-verified image.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            lo_q, lo_d;
    logic [7:0]            chk_q, chk_d;
    logic [ADDR_W:0]       cnt_q, cnt_d;
    logic [15:0]           len_full;
    logic [BYTES_PER_WORD*8-1:0] word;
    logic                  accept;
    logic                  frame_st;
    logic                  expired;

    assign accept   = rx_valid && rx_ready;
    assign frame_st = is_frame_state(state_q);
    assign len_full = {len_q[15:8], rx_data};

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .clr_i    (accept || !frame_st),
        .en_i     (frame_st),
        .expired_o(expired)
    );

    // Frame parser: next state, word assembly, checksum and word counter.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        rx_ready = (state_q != WRITE);
        wr_en    = (state_q == WRITE);
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = LEN_HI;
                    chk_d   = '0;
                    cnt_d   = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    chk_d       = chk_q ^ rx_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    chk_d      = chk_q ^ rx_data;
                    if (len_full == 16'd0) begin
                        state_d = CHECK;
                    end else if (32'(len_full) > (32'd1 << ADDR_W)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (32'(cnt_d) == 32'(len_q)) ? CHECK : DATA_HI;
            end
            CHECK: begin
                if (accept) begin
                    state_d = (rx_data == chk_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
        // expired is already masked by an accepted byte, so this never overrides one.
        if (frame_st && expired) begin
            state_d = ERROR;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            chk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            chk_q   <= chk_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word      = {hi_q, lo_q};
    assign wr_data   = word;
    assign wr_addr   = cnt_q[ADDR_W-1:0];
    assign cpu_reset = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);

endmodule
